dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder for the MEM-stage memory interface.
- Accepts one load/store request at a time over a valid/ready handshake and applies a configurable wait-state latency.
- Performs word/half/byte access with byte-lane masking and load extension, then returns a one-cycle response pulse carrying read data or an error flag.
- Intended to replace the zero-latency data memory once the pipeline gains stall support.

Parameters:
- ADDR_W, 10, word-address bits; storage depth is 2^ADDR_W 32-bit words.
- WAIT, 2, wait-state cycles inserted between acceptance and response (0..15).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_len  input  2  00 word, 01 half, 10 byte, 11 illegal.
- req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  output  1  one-cycle response pulse.
- resp_rdata  output  32  load result; 0 for stores and errors.
- resp_err  output  1  misaligned or illegal request; qualified by resp_valid.
- busy  output  1  request in flight (state != IDLE).

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE; req_ready = 1; resp_valid = 0; resp_rdata = 0; resp_err = 0; busy = 0; wait counter = 0.
  - RAM contents are not cleared by reset.
- Handshake:
  - A request is accepted on the edge where req_valid && req_ready.
  - All req_* fields are captured at acceptance; later input changes are ignored until the next acceptance.
  - req_ready = 1 only in IDLE. No back-to-back acceptance: the next request can be accepted in the cycle after resp_valid.
- FSM states: IDLE, WAIT, RESP.
  - IDLE -> WAIT on acceptance if WAIT > 0; counter loaded with WAIT-1.
  - IDLE -> RESP on acceptance if WAIT == 0.
  - WAIT: counter decrements each cycle; -> RESP when counter == 0.
  - RESP: resp_valid = 1 for exactly this one cycle; -> IDLE unconditionally. The requester cannot backpressure.
- Latency:
  - Acceptance edge at cycle T; resp_valid is high during cycle T+1+WAIT.
  - A store's RAM write commits on the edge that enters RESP.
  - A load's data is sampled on that same edge, so it reflects every store whose response has already pulsed.
- Addressing:
  - Word index = req_addr[ADDR_W+1:2]; upper address bits are ignored, so out-of-range addresses alias/wrap.
  - Lane k = req_addr[1:0]; little-endian: byte k occupies bits [8k+7:8k].
- Alignment/error:
  - Half with addr[0] = 1, word with addr[1:0] != 0, or req_len = 11 -> resp_err = 1, resp_rdata = 0, no RAM write.
  - An error response still goes through the full WAIT latency.
- Stores:
  - Byte: write lane k with wdata[7:0].
  - Half: write lanes k, k+1 with wdata[15:0].
  - Word: write all four lanes.
  - Unselected lanes are unchanged.
- Loads:
  - Extract the selected byte/half and right-align it.
  - Extend to 32 bits per req_unsigned; word loads ignore req_unsigned.
- Outputs outside RESP: resp_valid = 0; resp_rdata and resp_err = 0.
- Reset mid-operation:
  - An in-flight request is dropped: no RAM write, no response.
  - Returns to IDLE with req_ready = 1 the cycle after rst is deasserted.
- req_valid asserted while busy has no effect and is not queued.

Test Plan:
- WAIT=2: store word 0xDEADBEEF to addr 0x10 accepted at cycle T; later load word 0x10 -> resp_valid at T+3 for each request, rdata 0xDEADBEEF, err 0.
- After the word above: store byte 0x5A to 0x11, then load word 0x10 -> 0xDEAD5AEF. Load byte 0x11 signed -> 0x0000005A. Store byte 0x80 to 0x12; load byte 0x12 signed -> 0xFFFFFF80, unsigned -> 0x00000080.
- Store half 0x8001 to 0x22; load half 0x22 signed -> 0xFFFF8001, unsigned -> 0x00008001. Word at 0x20 has bits [15:0] unchanged.
- Load word 0x13, load half 0x21, and req_len = 11 -> each gives resp_err = 1, rdata 0. A store word to 0x13 leaves memory unchanged (verified by a subsequent aligned read).
- Assert rst during WAIT of a store word 0x12345678 to 0x30 -> no resp_valid, busy = 0 and req_ready = 1 after reset; load 0x30 returns the prior contents.
- WAIT=0: accept at T -> resp_valid at T+1, req_ready low in T+1, next acceptance possible at T+2. req_valid held high continuously yields a response every 2 cycles. Address 0x1010 with ADDR_W=10 aliases 0x0010.

Source files
------------

// File: rtl/dmem_responder_if.sv
// ============================================================================
// Module      : dmem_responder_if
// Description : Request/response bundle between the MEM stage and the data
//               memory responder.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_len;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;

    modport master (
        output req_valid, req_we, req_len, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_len, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err, busy
    );
endinterface

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
// Module      : dmem_responder
// Description : Single-outstanding data-memory responder with wait states,
//               byte-lane stores and sign/zero-extended loads.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module dmem_responder #(
    parameter int ADDR_W = 10,
    parameter int WAIT   = 2
) (
    input  logic             clk,
    input  logic             rst,
    dmem_responder_if.slave  bus
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_WAIT   = 2'd1;
    localparam logic [1:0] c_ST_RESP   = 2'd2;
    localparam int         c_DEPTH     = 1 << ADDR_W;
    localparam logic [3:0] c_WAIT_LOAD = 4'((WAIT > 0) ? (WAIT - 1) : 0);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [3:0]        r_cnt;
    logic [3:0]        w_cnt_nxt;

    logic              r_we;
    logic [1:0]        r_len;
    logic              r_unsigned;
    logic [31:0]       r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic              r_err;

    logic [31:0]       r_mem [c_DEPTH];

    logic              w_idle;
    logic              w_accept;
    logic              w_enter_resp;
    logic              w_we;
    logic [1:0]        w_len;
    logic              w_unsigned;
    logic [31:0]       w_addr;
    logic [31:0]       w_wdata;
    logic [ADDR_W-1:0] w_idx;
    logic [1:0]        w_lane;
    logic              w_err;
    logic [31:0]       w_word;
    logic [31:0]       w_shift;
    logic [31:0]       w_load;
    logic [31:0]       w_wdata_al;
    logic [3:0]        w_be;
    logic              w_unused_addr;

    assign w_idle   = (r_state == c_ST_IDLE);
    assign w_accept = w_idle && bus.req_valid;

    // With zero wait states RESP is entered on the acceptance edge itself,
    // so the live request fields must be used instead of the captured copy.
    assign w_we       = w_idle ? bus.req_we       : r_we;
    assign w_len      = w_idle ? bus.req_len      : r_len;
    assign w_unsigned = w_idle ? bus.req_unsigned : r_unsigned;
    assign w_addr     = w_idle ? bus.req_addr     : r_addr;
    assign w_wdata    = w_idle ? bus.req_wdata    : r_wdata;

    assign w_idx         = w_addr[ADDR_W+1:2];
    assign w_lane        = w_addr[1:0];
    assign w_unused_addr = ^w_addr[31:ADDR_W+2];

    assign w_err = (w_len == 2'b11)
                || ((w_len == 2'b01) && w_lane[0])
                || ((w_len == 2'b00) && (w_lane != 2'b00));

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    if (WAIT > 0) begin
                        w_state_nxt = c_ST_WAIT;
                        w_cnt_nxt   = c_WAIT_LOAD;
                    end else begin
                        w_state_nxt = c_ST_RESP;
                    end
                end
            end
            c_ST_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = c_ST_RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            c_ST_RESP: w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign w_enter_resp = (w_state_nxt == c_ST_RESP) && (r_state != c_ST_RESP);

    assign w_word  = r_mem[w_idx];
    assign w_shift = w_word >> {w_lane, 3'b000};

    always_comb begin
        w_load = 32'd0;
        case (w_len)
            2'b00:   w_load = w_word;
            2'b01:   w_load = w_unsigned ? {16'd0, w_shift[15:0]}
                                         : {{16{w_shift[15]}}, w_shift[15:0]};
            2'b10:   w_load = w_unsigned ? {24'd0, w_shift[7:0]}
                                         : {{24{w_shift[7]}}, w_shift[7:0]};
            default: w_load = 32'd0;
        endcase
    end

    assign w_wdata_al = w_wdata << {w_lane, 3'b000};

    always_comb begin
        w_be = 4'b0000;
        case (w_len)
            2'b00:   w_be = 4'b1111;
            2'b01:   w_be = 4'b0011 << w_lane;
            2'b10:   w_be = 4'b0001 << w_lane;
            default: w_be = 4'b0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_we       <= 1'b0;
            r_len      <= 2'b00;
            r_unsigned <= 1'b0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_rdata    <= 32'd0;
            r_err      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we       <= bus.req_we;
                r_len      <= bus.req_len;
                r_unsigned <= bus.req_unsigned;
                r_addr     <= bus.req_addr;
                r_wdata    <= bus.req_wdata;
            end
            if (w_enter_resp) begin
                r_rdata <= (w_err || w_we) ? 32'd0 : w_load;
                r_err   <= w_err;
            end
        end
    end

    // Storage is deliberately not reset; a reset only suppresses the commit.
    always_ff @(posedge clk) begin
        if (!rst && w_enter_resp && w_we && !w_err) begin
            for (int k = 0; k < 4; k++) begin
                if (w_be[k]) begin
                    r_mem[w_idx][8*k +: 8] <= w_wdata_al[8*k +: 8];
                end
            end
        end
    end

    assign bus.req_ready  = w_idle;
    assign bus.busy       = !w_idle;
    assign bus.resp_valid = (r_state == c_ST_RESP);
    assign bus.resp_rdata = (r_state == c_ST_RESP) ? r_rdata : 32'd0;
    assign bus.resp_err   = (r_state == c_ST_RESP) ? r_err : 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
// Module      : tb_dmem_responder
// Description : Directed bench for two responders (WAIT=2 and WAIT=0) against
//               a byte-array memory model with per-cycle output comparison.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_dmem_responder;

    localparam int c_ADDR_W = 10;
    localparam int c_WAIT_A = 2;
    localparam int c_WAIT_B = 0;
    localparam int c_MASK   = (1 << (c_ADDR_W + 2)) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_responder_if bus_a ();
    dmem_responder_if bus_b ();

    logic        d_valid [2];
    logic        d_we    [2];
    logic [1:0]  d_len   [2];
    logic        d_uns   [2];
    logic [31:0] d_addr  [2];
    logic [31:0] d_wdata [2];

    logic        o_ready [2];
    logic        o_valid [2];
    logic [31:0] o_rdata [2];
    logic        o_err   [2];
    logic        o_busy  [2];

    assign bus_a.req_valid    = d_valid[0];
    assign bus_a.req_we       = d_we[0];
    assign bus_a.req_len      = d_len[0];
    assign bus_a.req_unsigned = d_uns[0];
    assign bus_a.req_addr     = d_addr[0];
    assign bus_a.req_wdata    = d_wdata[0];
    assign bus_b.req_valid    = d_valid[1];
    assign bus_b.req_we       = d_we[1];
    assign bus_b.req_len      = d_len[1];
    assign bus_b.req_unsigned = d_uns[1];
    assign bus_b.req_addr     = d_addr[1];
    assign bus_b.req_wdata    = d_wdata[1];

    assign o_ready[0] = bus_a.req_ready;
    assign o_valid[0] = bus_a.resp_valid;
    assign o_rdata[0] = bus_a.resp_rdata;
    assign o_err[0]   = bus_a.resp_err;
    assign o_busy[0]  = bus_a.busy;
    assign o_ready[1] = bus_b.req_ready;
    assign o_valid[1] = bus_b.resp_valid;
    assign o_rdata[1] = bus_b.resp_rdata;
    assign o_err[1]   = bus_b.resp_err;
    assign o_busy[1]  = bus_b.busy;

    dmem_responder #(.ADDR_W(c_ADDR_W), .WAIT(c_WAIT_A)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    dmem_responder #(.ADDR_W(c_ADDR_W), .WAIT(c_WAIT_B)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    // Model: one request in flight, response pulses in cycle accept+1+WAIT,
    // memory effect happens on the last edge before that cycle.
    bit          m_busy     [2];
    int          m_resp_cyc [2];
    logic [31:0] m_exp_data [2];
    logic        m_exp_err  [2];
    logic [7:0]  m_mem      [2][1 << (c_ADDR_W + 2)];
    logic        p_we       [2];
    logic [1:0]  p_len      [2];
    logic        p_uns      [2];
    logic [31:0] p_addr     [2];
    logic [31:0] p_wdata    [2];

    function automatic int lat_of(input int d);
        return (d == 0) ? c_WAIT_A : c_WAIT_B;
    endfunction

    task automatic chk(input string nm, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (dut%0d, cycle %0d): actual %h, required %h",
                     nm, d, cyc, act, exp);
        end
    endtask

    task automatic commit(input int d);
        int          n;
        int          ba;
        logic [31:0] val;
        n  = (p_len[d] == 2'd0) ? 4 : (p_len[d] == 2'd1) ? 2 : 1;
        ba = int'(p_addr[d]) & c_MASK;
        m_exp_err[d]  = (p_len[d] == 2'd3) || ((ba % n) != 0);
        m_exp_data[d] = 32'd0;
        if (!m_exp_err[d]) begin
            if (p_we[d]) begin
                for (int i = 0; i < n; i++) m_mem[d][ba + i] = p_wdata[d][8*i +: 8];
            end else begin
                val = 32'd0;
                for (int i = 0; i < n; i++) val = val | (32'(m_mem[d][ba + i]) << (8 * i));
                if (!p_uns[d] && n < 4 && val[8*n - 1]) val = val | (32'hFFFF_FFFF << (8 * n));
                m_exp_data[d] = val;
            end
        end
    endtask

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_busy[d] = 1'b0;
            end else begin
                if (m_busy[d] && cyc == m_resp_cyc[d]) begin
                    m_busy[d] = 1'b0;
                end else if (!m_busy[d] && d_valid[d]) begin
                    p_we[d]       = d_we[d];
                    p_len[d]      = d_len[d];
                    p_uns[d]      = d_uns[d];
                    p_addr[d]     = d_addr[d];
                    p_wdata[d]    = d_wdata[d];
                    m_busy[d]     = 1'b1;
                    m_resp_cyc[d] = cyc + 1 + lat_of(d);
                end
                if (m_busy[d] && (cyc + 1) == m_resp_cyc[d]) commit(d);
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                automatic bit ev = m_busy[d] && (cyc == m_resp_cyc[d]);
                chk("req_ready",  d, 32'(o_ready[d]), 32'(!m_busy[d]));
                chk("busy",       d, 32'(o_busy[d]),  32'(m_busy[d]));
                chk("resp_valid", d, 32'(o_valid[d]), 32'(ev));
                chk("resp_rdata", d, o_rdata[d], ev ? m_exp_data[d] : 32'd0);
                chk("resp_err",   d, 32'(o_err[d]),   32'(ev && m_exp_err[d]));
            end
        end
    end

    task automatic do_req(input int d, input logic we, input logic [1:0] len,
                          input logic uns, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] exp_rd,
                          input logic exp_er, input string nm);
        int acc;
        bit got;
        @(posedge clk); #1;
        d_valid[d] = 1'b1; d_we[d] = we; d_len[d] = len;
        d_uns[d] = uns; d_addr[d] = addr; d_wdata[d] = wd;
        got = 1'b0;
        acc = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (o_ready[d]) begin
                got = 1'b1;
                acc = cyc;
            end else begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        // Disturb the live fields to show the captured copy is what counts.
        d_valid[d] = 1'b0; d_we[d] = ~we; d_addr[d] = addr ^ 32'h4;
        d_wdata[d] = ~wd; d_uns[d] = ~uns;
        if (!got) begin
            chk({nm, "_accept_timeout"}, d, 32'd0, 32'd1);
            return;
        end
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (o_valid[d]) got = 1'b1;
        end
        if (!got) begin
            chk({nm, "_resp_timeout"}, d, 32'd0, 32'd1);
            return;
        end
        chk({nm, "_rdata"},   d, o_rdata[d], exp_rd);
        chk({nm, "_err"},     d, 32'(o_err[d]), 32'(exp_er));
        chk({nm, "_latency"}, d, 32'(cyc - acc), 32'(1 + lat_of(d)));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: actual timeout, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        for (int d = 0; d < 2; d++) begin
            d_valid[d] = 1'b0; d_we[d] = 1'b0; d_len[d] = 2'd0;
            d_uns[d] = 1'b0; d_addr[d] = 32'd0; d_wdata[d] = 32'd0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset_ready", d, 32'(o_ready[d]), 32'd1);
            chk("reset_valid", d, 32'(o_valid[d]), 32'd0);
            chk("reset_busy",  d, 32'(o_busy[d]),  32'd0);
            chk("reset_rdata", d, o_rdata[d],      32'd0);
        end

        // WAIT=2 responder
        do_req(0, 1, 2'd0, 0, 32'h10, 32'hDEAD_BEEF, 32'h0,         0, "st_w10");
        do_req(0, 0, 2'd0, 0, 32'h10, 32'h0,         32'hDEAD_BEEF, 0, "ld_w10");
        do_req(0, 1, 2'd2, 0, 32'h11, 32'h1234_565A, 32'h0,         0, "st_b11");
        do_req(0, 0, 2'd0, 0, 32'h10, 32'h0,         32'hDEAD_5AEF, 0, "ld_w10b");
        do_req(0, 0, 2'd2, 0, 32'h11, 32'h0,         32'h0000_005A, 0, "ld_b11s");
        do_req(0, 1, 2'd2, 0, 32'h12, 32'h0000_0080, 32'h0,         0, "st_b12");
        do_req(0, 0, 2'd2, 0, 32'h12, 32'h0,         32'hFFFF_FF80, 0, "ld_b12s");
        do_req(0, 0, 2'd2, 1, 32'h12, 32'h0,         32'h0000_0080, 0, "ld_b12u");
        do_req(0, 1, 2'd0, 0, 32'h20, 32'h1122_3344, 32'h0,         0, "st_w20");
        do_req(0, 1, 2'd1, 0, 32'h22, 32'hABCD_8001, 32'h0,         0, "st_h22");
        do_req(0, 0, 2'd1, 0, 32'h22, 32'h0,         32'hFFFF_8001, 0, "ld_h22s");
        do_req(0, 0, 2'd1, 1, 32'h22, 32'h0,         32'h0000_8001, 0, "ld_h22u");
        do_req(0, 0, 2'd0, 0, 32'h20, 32'h0,         32'h8001_3344, 0, "ld_w20");
        do_req(0, 0, 2'd0, 0, 32'h13, 32'h0,         32'h0,         1, "ld_w13");
        do_req(0, 0, 2'd1, 0, 32'h21, 32'h0,         32'h0,         1, "ld_h21");
        do_req(0, 0, 2'd3, 0, 32'h10, 32'h0,         32'h0,         1, "ld_len3");
        do_req(0, 1, 2'd0, 0, 32'h13, 32'hFFFF_FFFF, 32'h0,         1, "st_w13");
        do_req(0, 0, 2'd0, 0, 32'h10, 32'h0,         32'hDE80_5AEF, 0, "ld_w10c");
        do_req(0, 1, 2'd0, 0, 32'h30, 32'hCAFE_F00D, 32'h0,         0, "st_w30");

        // Reset while a store sits in its wait states.
        @(posedge clk); #1;
        d_valid[0] = 1'b1; d_we[0] = 1'b1; d_len[0] = 2'd0;
        d_addr[0] = 32'h30; d_wdata[0] = 32'h1234_5678;
        @(negedge clk);
        chk("rst_pre_ready", 0, 32'(o_ready[0]), 32'd1);
        @(posedge clk); #1;
        d_valid[0] = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy",  0, 32'(o_busy[0]),  32'd0);
        chk("rst_ready", 0, 32'(o_ready[0]), 32'd1);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (o_valid[0]) cnt++;
        end
        chk("rst_no_resp", 0, 32'(cnt), 32'd0);
        do_req(0, 0, 2'd0, 0, 32'h30, 32'h0, 32'hCAFE_F00D, 0, "ld_w30");

        // WAIT=0 responder, including address aliasing.
        do_req(1, 1, 2'd0, 0, 32'h0010, 32'hA5A5_0F0F, 32'h0,         0, "z_st_w10");
        do_req(1, 0, 2'd0, 0, 32'h1010, 32'h0,         32'hA5A5_0F0F, 0, "z_ld_alias");
        do_req(1, 0, 2'd2, 1, 32'h0013, 32'h0,         32'h0000_00A5, 0, "z_ld_b13u");
        do_req(1, 0, 2'd2, 0, 32'h0013, 32'h0,         32'hFFFF_FFA5, 0, "z_ld_b13s");

        // Continuously valid: one response every second cycle.
        @(posedge clk); #1;
        d_valid[1] = 1'b1; d_we[1] = 1'b0; d_len[1] = 2'd0;
        d_uns[1] = 1'b0; d_addr[1] = 32'h1010;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (o_valid[1]) cnt++;
        end
        chk("z_stream_pulses", 1, 32'(cnt), 32'd4);
        @(posedge clk); #1;
        d_valid[1] = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
